// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous memory.
// Optional error counter output err_cnt is enabled by defining MEM_ARB_ERRCNT_EN.
module mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_perr,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_perr,

    output logic              mem_ce,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_valid,
    input  logic              mem_perr
`ifdef MEM_ARB_ERRCNT_EN
    ,
    output logic [15:0]       err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } state_t;

    state_t state;
    logic   grant_b;
    logic   last_grant_b;
    logic   req_we;
    logic   pick_b;
    logic   sel_we;
    logic   cap_perr;

    // B wins only when A is idle or A had the previous grant.
    assign pick_b   = b_req && (!a_req || !last_grant_b);
    assign sel_we   = pick_b ? b_we : a_we;
    assign cap_perr = mem_perr | ~mem_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant_b      <= 1'b0;
            last_grant_b <= 1'b1;
            req_we       <= 1'b0;
            a_ack        <= 1'b0;
            b_ack        <= 1'b0;
            a_rvalid     <= 1'b0;
            b_rvalid     <= 1'b0;
            a_rdata      <= '0;
            b_rdata      <= '0;
            a_perr       <= 1'b0;
            b_perr       <= 1'b0;
            mem_ce       <= 1'b0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= '0;
        end else begin
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    mem_ce <= 1'b0;
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    if (a_req || b_req) begin
                        grant_b      <= pick_b;
                        last_grant_b <= pick_b;
                        req_we       <= sel_we;
                        mem_addr     <= pick_b ? b_addr : a_addr;
                        mem_din      <= pick_b ? b_wdata : a_wdata;
                        mem_ce       <= 1'b1;
                        mem_rd       <= ~sel_we;
                        mem_wr       <= sel_we;
                        a_ack        <= ~pick_b;
                        b_ack        <= pick_b;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    if (req_we) begin
                        mem_ce <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        mem_ce <= 1'b1;
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    mem_ce <= 1'b0;
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    state  <= IDLE;
                    if (grant_b) begin
                        b_rvalid <= 1'b1;
                        b_rdata  <= mem_dout;
                        b_perr   <= cap_perr;
                    end else begin
                        a_rvalid <= 1'b1;
                        a_rdata  <= mem_dout;
                        a_perr   <= cap_perr;
                    end
                end
                default: begin
                    mem_ce <= 1'b0;
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_ERRCNT_EN
    // Counts errored read returns; sticks at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (state == CAPTURE && cap_perr && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              a_req, a_we, b_req, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic              a_ack, a_rvalid, a_perr, b_ack, b_rvalid, b_perr;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic              mem_ce, mem_rd, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din, mem_dout;
    logic              mem_valid, mem_perr;
`ifdef MEM_ARB_ERRCNT_EN
    logic [15:0]       err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_perr(a_perr),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_perr(b_perr),
        .mem_ce(mem_ce), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_valid(mem_valid), .mem_perr(mem_perr)
`ifdef MEM_ARB_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data appears the cycle after mem_rd; address 0x3FF reports a parity error.
    always @(posedge clk) begin
        if (mem_ce && mem_wr) mem[mem_addr] <= mem_din;
        if (mem_ce && mem_rd) begin
            mem_dout  <= mem[mem_addr];
            mem_valid <= 1'b1;
            mem_perr  <= (mem_addr == 10'h3FF);
        end else begin
            mem_valid <= 1'b0;
            mem_perr  <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mem_rd && mem_wr) overlap_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic ar, input logic aw, input logic [ADDR_W-1:0] aa,
                                  input logic [DATA_W-1:0] ad, input logic br, input logic bw,
                                  input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    endtask

    initial begin
        for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
        mem[10'h3FF] = 32'h1234_5678;
        mem_dout = '0; mem_valid = 1'b0; mem_perr = 1'b0;
        rst = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        check_output("rst_a_ack", a_ack, 0);
        check_output("rst_mem_ce", mem_ce, 0);
        check_output("rst_mem_addr", mem_addr, 0);
        check_output("rst_a_rdata", a_rdata, 0);
`ifdef MEM_ARB_ERRCNT_EN
        check_output("rst_err_cnt", err_cnt, 0);
`endif
        rst = 1'b0;
        tick();

        // Write from A
        apply_stimulus(1, 1, 10'h005, 32'hDEAD_BEEF, 0, 0, 0, 0);
        tick();
        check_output("wr_a_ack", a_ack, 1);
        check_output("wr_b_ack", b_ack, 0);
        check_output("wr_mem_wr", mem_wr, 1);
        check_output("wr_mem_rd", mem_rd, 0);
        check_output("wr_mem_ce", mem_ce, 1);
        check_output("wr_mem_addr", mem_addr, 10'h005);
        check_output("wr_mem_din", mem_din, 32'hDEAD_BEEF);
        a_req = 1'b0;
        tick();
        check_output("wr_done_ce", mem_ce, 0);
        check_output("wr_done_ack", a_ack, 0);

        // Read back from B
        apply_stimulus(0, 0, 0, 0, 1, 0, 10'h005, 0);
        tick();
        check_output("rd_b_ack", b_ack, 1);
        check_output("rd_mem_rd", mem_rd, 1);
        check_output("rd_mem_addr", mem_addr, 10'h005);
        b_req = 1'b0;
        tick();
        check_output("cap_mem_ce", mem_ce, 1);
        check_output("cap_mem_rd", mem_rd, 0);
        check_output("cap_b_rvalid", b_rvalid, 0);
        a_req = 1'b1; a_we = 1'b0; a_addr = 10'h005;
        tick();
        check_output("rd_b_rvalid", b_rvalid, 1);
        check_output("rd_b_rdata", b_rdata, 32'hDEAD_BEEF);
        check_output("rd_b_perr", b_perr, 0);
        check_output("rd_a_rvalid", a_rvalid, 0);
        check_output("rd_a_rdata", a_rdata, 0);
        a_req = 1'b0;
        tick();
        check_output("late_req_a_ack", a_ack, 0);
        check_output("late_req_ce", mem_ce, 0);
        check_output("hold_b_rvalid", b_rvalid, 0);
        check_output("hold_b_rdata", b_rdata, 32'hDEAD_BEEF);

        // Parity error read from A, then B granted in the rvalid cycle
        apply_stimulus(1, 0, 10'h3FF, 0, 0, 0, 0, 0);
        tick();
        check_output("par_a_ack", a_ack, 1);
        a_req = 1'b0;
        tick();
        tick();
        check_output("par_a_rvalid", a_rvalid, 1);
        check_output("par_a_perr", a_perr, 1);
        check_output("par_a_rdata", a_rdata, 32'h1234_5678);
        check_output("par_b_rdata_hold", b_rdata, 32'hDEAD_BEEF);
`ifdef MEM_ARB_ERRCNT_EN
        check_output("par_err_cnt", err_cnt, 1);
`endif
        apply_stimulus(0, 0, 0, 0, 1, 0, 10'h005, 0);
        tick();
        check_output("b2b_b_ack", b_ack, 1);
        check_output("b2b_a_rvalid", a_rvalid, 0);
        b_req = 1'b0;
        tick();
        tick();
        check_output("b2b_b_rvalid", b_rvalid, 1);
        check_output("b2b_b_perr", b_perr, 0);
        check_output("b2b_a_perr_hold", a_perr, 1);

        // Reset during CAPTURE of an A read
        apply_stimulus(1, 0, 10'h005, 0, 0, 0, 0, 0);
        tick();
        check_output("abort_a_ack", a_ack, 1);
        a_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_output("abort_a_rvalid", a_rvalid, 0);
        check_output("abort_mem_ce", mem_ce, 0);
        rst = 1'b0;
        tick();
        check_output("abort_idle_rvalid", a_rvalid, 0);

        // Contention: both requesters write continuously
        apply_stimulus(1, 1, 10'h010, 32'hAAAA_0001, 1, 1, 10'h020, 32'hBBBB_0002);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_output($sformatf("cont%0d_a_ack", k), a_ack, (k % 2 == 0) ? 1 : 0);
            check_output($sformatf("cont%0d_b_ack", k), b_ack, (k % 2 == 1) ? 1 : 0);
            tick();
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_output("cont_mem_a", mem[10'h010], 32'hAAAA_0001);
        check_output("cont_mem_b", mem[10'h020], 32'hBBBB_0002);
        check_output("no_overlap", overlap_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Ports a_req/b_req  input  1  requester A/B operation request; held until ack.
REQ-006 Ports a_we/b_we  input  1  1=write, 0=read; stable while req is high.
REQ-007 Ports a_addr/b_addr  input  ADDR_W  word address.
REQ-008 Ports a_wdata/b_wdata  input  DATA_W  write data.
REQ-009 Ports a_ack/b_ack  output  1  one-cycle pulse; request accepted and issued.
REQ-010 Ports a_rvalid/b_rvalid  output  1  one-cycle pulse; read data returned.
REQ-011 Ports a_rdata/b_rdata  output  DATA_W  read data; valid with rvalid.
REQ-012 Ports a_perr/b_perr  output  1  read parity/validity error; valid with rvalid.
REQ-013 Ports mem_ce, mem_rd, mem_wr  output  1 each  memory chip enable, read, write.
REQ-014 Ports mem_addr  output  ADDR_W; mem_din  output  DATA_W  memory address and write data.
REQ-015 Ports mem_dout  input  DATA_W; mem_valid, mem_perr  input  1  memory read data, valid, parity error.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, CAPTURE.
REQ-017 In IDLE, when any req is high, the block SHALL grant one requester, register its we/addr/wdata, and enter ISSUE next cycle.
REQ-018 Arbitration SHALL be round-robin: with both req high, grant the requester not granted last; with one req high, grant it.
REQ-019 In ISSUE the block SHALL drive mem_ce=1, mem_addr/mem_din from the registered request, mem_rd=~we, mem_wr=we, and pulse the granted ack.
REQ-020 After ISSUE, a write SHALL return to IDLE; a read SHALL enter CAPTURE.
REQ-021 In CAPTURE the block SHALL hold mem_ce=1 with mem_rd=mem_wr=0, sample mem_dout, and return to IDLE.
REQ-022 In the cycle after CAPTURE, the granted requester's rvalid SHALL pulse, with rdata=sampled mem_dout and perr=mem_perr|~mem_valid as sampled in CAPTURE.
REQ-023 Read latency SHALL be 2 cycles from ack to rvalid; a read occupies 3 cycles and a write 2 cycles, with IDLE included.
REQ-024 mem_rd and mem_wr SHALL never both be 1; mem_ce SHALL be 0 in IDLE.
REQ-025 req SHALL be sampled only in IDLE; a req dropped before grant SHALL be ignored with no ack.
REQ-026 rdata/perr SHALL hold their last values between rvalid pulses; the non-granted requester's outputs SHALL not change.
REQ-027 A new request SHALL be grantable in the same cycle that the previous read's rvalid pulses.

Reset
REQ-028 On rst: FSM=IDLE; all ack, rvalid, perr, mem_ce, mem_rd, mem_wr=0; rdata, mem_addr, mem_din=0; the round-robin pointer SHALL make A win the first contention.
REQ-029 rst during ISSUE or CAPTURE SHALL abort the operation, suppress any pending ack or rvalid, and drop mem_ce in the next cycle.

Configuration
REQ-030 With macro MEM_ARB_ERRCNT_EN defined, output err_cnt (16 bits) SHALL count rvalid pulses with perr=1, saturate at 16'hFFFF, and reset to 0.
REQ-031 Without MEM_ARB_ERRCNT_EN, the port err_cnt and its counter SHALL be absent.

Verification
REQ-032 Test A write: a_req, a_we=1, a_addr=0x005, a_wdata=0xDEADBEEF -> a_ack in cycle 2, mem_wr=1 with addr 0x005 in the same cycle.
REQ-033 Test B read back: b_req, b_we=0, b_addr=0x005 after the write -> b_ack, then b_rvalid 2 cycles later with b_rdata=0xDEADBEEF and b_perr=0.
REQ-034 Contention: a_req and b_req held high for 4 operations right after reset -> grant order A, B, A, B; no overlap on mem_rd/mem_wr.
REQ-035 Parity error: model returns mem_perr=1 on a read of 0x3FF -> rvalid with perr=1; with MEM_ARB_ERRCNT_EN defined, err_cnt goes 0 to 1.
REQ-036 Reset mid-read: rst asserted in CAPTURE -> no rvalid, mem_ce=0 next cycle, and the next contention grants A.
